sar_ctrl: RTL and testbench

//  Successive-approximation controller feeding the capacitor-driver stage: produces the dac_state
//  bus and dac_drive_invert consumed by the driver, and sequences the comparator per bit.
//  One conversion = track phase + NBITS binary-search trials; the final code is published on result.

---
 rtl/sar_ctrl.sv | 118 +++++++++++
 tb/tb_sar_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sar_ctrl.sv
// SAR conversion sequencer: track phase, then one MSB-first comparator trial per bit; result after SAMPLE_CYCLES+2*NBITS+1 cycles.
// No backpressure: start is only taken in IDLE, and a missing comp_done forces the bit to 0 after TIMEOUT cycles.
module sar_ctrl #(
  parameter int NBITS         = 16,
  parameter int SAMPLE_CYCLES = 2,
  parameter int TIMEOUT       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             invert_cfg,
  input  logic             comp_done,
  input  logic             comp_out,
  output logic             comp_start,
  output logic             sample,
  output logic             busy,
  output logic [NBITS-1:0] dac_state,
  output logic             dac_drive_invert,
  output logic [NBITS-1:0] result,
  output logic             result_valid,
  output logic             timeout_err
);

  localparam int IW   = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int CMAX = (SAMPLE_CYCLES > TIMEOUT) ? SAMPLE_CYCLES : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [IW-1:0] TOP_BIT     = IW'(NBITS - 1);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES);
  localparam logic [CW-1:0] WAIT_LAST   = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    TRIAL,
    WAIT,
    DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] bit_idx;
  // Shared by the track-phase length and the per-bit comparator timeout.
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      bit_idx          <= TOP_BIT;
      cnt              <= '0;
      comp_start       <= 1'b0;
      sample           <= 1'b0;
      busy             <= 1'b0;
      dac_state        <= '0;
      dac_drive_invert <= 1'b1;
      result           <= '0;
      result_valid     <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state            <= SAMPLE;
            dac_state        <= '0;
            dac_drive_invert <= invert_cfg;
            timeout_err      <= 1'b0;
            busy             <= 1'b1;
            sample           <= 1'b1;
            bit_idx          <= TOP_BIT;
            cnt              <= CW'(1);
          end
        end
        SAMPLE: begin
          if (cnt == SAMPLE_LAST) begin
            state              <= TRIAL;
            sample             <= 1'b0;
            comp_start         <= 1'b1;
            dac_state[bit_idx] <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TRIAL: begin
          comp_start <= 1'b0;
          cnt        <= CW'(1);
          state      <= WAIT;
        end
        WAIT: begin
          // A decision arriving on the timeout cycle still counts as a real decision.
          if (comp_done || cnt == WAIT_LAST) begin
            dac_state[bit_idx] <= comp_done & comp_out;
            if (!comp_done) begin
              timeout_err <= 1'b1;
            end
            if (bit_idx != '0) begin
              dac_state[bit_idx - 1'b1] <= 1'b1;
              comp_start                <= 1'b1;
              bit_idx                   <= bit_idx - 1'b1;
              state                     <= TRIAL;
            end else begin
              state <= DONE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          result       <= dac_state;
          result_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_ctrl.sv
// Directed bench for sar_ctrl: table of conversions against a delayed-strobe comparator model, plus a mid-conversion reset sequence.
module tb_sar_ctrl;

  localparam int NB = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          invert_cfg = 1'b1;
  logic          comp_done = 1'b0;
  logic          comp_out = 1'b0;
  logic          comp_start;
  logic          sample;
  logic          busy;
  logic [NB-1:0] dac_state;
  logic          dac_drive_invert;
  logic [NB-1:0] result;
  logic          result_valid;
  logic          timeout_err;

  sar_ctrl #(.NBITS(NB), .SAMPLE_CYCLES(2), .TIMEOUT(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .invert_cfg       (invert_cfg),
    .comp_done        (comp_done),
    .comp_out         (comp_out),
    .comp_start       (comp_start),
    .sample           (sample),
    .busy             (busy),
    .dac_state        (dac_state),
    .dac_drive_invert (dac_drive_invert),
    .result           (result),
    .result_valid     (result_valid),
    .timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  // Comparator model configuration, written only by the stimulus process.
  logic [NB-1:0] cfg_vin = '0;
  int            cfg_stuck = -1;
  bit            cfg_hold = 1'b0;

  // Comparator model: decision strobe one cycle after comp_start, or held high.
  bit pend = 1'b0;
  bit pend_out = 1'b0;
  int ncs = 0;
  always @(negedge clk) begin
    if (cfg_hold) begin
      comp_done = 1'b1;
      comp_out  = (cfg_vin >= dac_state);
    end else begin
      comp_done = pend;
      comp_out  = pend_out;
    end
    if (sample) ncs = 0;
    pend     = comp_start && ((NB - 1 - ncs) != cfg_stuck);
    pend_out = (cfg_vin >= dac_state);
    if (comp_start) ncs++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [NB-1:0] vin;
    int            stuck;
    bit            hold;
    bit            inv;
    logic [NB-1:0] exp_res;
    bit            exp_to;
    int            exp_lat;
  } vec_t;

  // Runs one conversion starting at the current negedge; returns at the
  // negedge where result_valid is seen, which is the first IDLE cycle.
  task automatic convert(input vec_t v);
    int            lat;
    int            n_cs;
    int            n_samp;
    int            inv_bad;
    int            busy_bad;
    int            cs_lat[NB];
    logic [NB-1:0] dac_first;
    logic          to_first;
    for (int i = 0; i < NB; i++) cs_lat[i] = 0;
    cfg_vin    = v.vin;
    cfg_stuck  = v.stuck;
    cfg_hold   = v.hold;
    invert_cfg = v.inv;
    start      = 1'b1;
    lat = -1; n_cs = 0; n_samp = 0; inv_bad = 0; busy_bad = 0;
    dac_first = '1; to_first = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      // Stray start pulses during TRIAL/WAIT must be ignored.
      start = (lat == 20 || lat == 21);
      if (lat == 10) invert_cfg = ~v.inv;
      if (lat == 0) begin
        dac_first = dac_state;
        to_first  = timeout_err;
      end
      if (comp_start) begin
        if (n_cs < NB) cs_lat[n_cs] = lat;
        n_cs++;
      end
      if (sample) n_samp++;
      if (dac_drive_invert != v.inv) inv_bad++;
      if (!result_valid && !busy) busy_bad++;
    end while (!result_valid && lat < 100);
    start = 1'b0;
    check("result", 32'(result), 32'(v.exp_res));
    check("timeout_err", 32'(timeout_err), 32'(v.exp_to));
    check("latency", 32'(lat), 32'(v.exp_lat));
    check("busy_at_done", 32'(busy), 32'(0));
    check("comp_start_count", 32'(n_cs), 32'(NB));
    check("sample_cycles", 32'(n_samp), 32'(2));
    check("first_trial_cycle", 32'(cs_lat[0]), 32'(2));
    check("invert_stable", 32'(inv_bad), 32'(0));
    check("busy_dropout", 32'(busy_bad), 32'(0));
    check("dac_cleared_at_start", 32'(dac_first), 32'(0));
    check("timeout_cleared_at_start", 32'(to_first), 32'(0));
    if (v.stuck > 0) begin
      // One TRIAL cycle plus exactly TIMEOUT WAIT cycles for the silent bit.
      check("stuck_bit_gap", 32'(cs_lat[NB - v.stuck] - cs_lat[NB - 1 - v.stuck]), 32'(9));
    end
  endtask

  vec_t vecs[6];
  int   rv_seen;

  initial begin
    vecs[0] = '{16'hA5C3, -1, 1'b0, 1'b1, 16'hA5C3, 1'b0, 35};
    vecs[1] = '{16'hFFFF, -1, 1'b0, 1'b1, 16'hFFFF, 1'b0, 35};
    vecs[2] = '{16'h0000, -1, 1'b0, 1'b1, 16'h0000, 1'b0, 35};
    vecs[3] = '{16'hFFFF,  7, 1'b0, 1'b1, 16'hFF7F, 1'b1, 42};
    vecs[4] = '{16'h1234, -1, 1'b0, 1'b0, 16'h1234, 1'b0, 35};
    vecs[5] = '{16'h8001, -1, 1'b1, 1'b1, 16'h8001, 1'b0, 35};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_dac_state", 32'(dac_state), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_invert", 32'(dac_drive_invert), 32'(1));
    check("rst_flags", {27'd0, comp_start, sample, busy, result_valid, timeout_err}, 32'(0));

    for (int i = 0; i < 6; i++) convert(vecs[i]);
    check("result_valid_pulse", 32'(result_valid), 32'(1));
    @(negedge clk);
    check("result_valid_single", 32'(result_valid), 32'(0));

    // Reset during the bit-10 trial.
    cfg_vin = 16'hA5C3; cfg_stuck = -1; cfg_hold = 1'b0;
    invert_cfg = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("bit10_trial_code", 32'(dac_state), 32'h0000_A400);
    rst_n = 1'b0;
    #1;
    check("arst_dac_state", 32'(dac_state), 32'(0));
    check("arst_result", 32'(result), 32'(0));
    check("arst_invert", 32'(dac_drive_invert), 32'(1));
    check("arst_flags", {27'd0, comp_start, sample, busy, result_valid, timeout_err}, 32'(0));
    rv_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (result_valid) rv_seen++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (result_valid) rv_seen++;
    end
    check("no_result_after_abort", 32'(rv_seen), 32'(0));
    convert(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
